// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the ARM-subset multicycle control unit.
// Includes the data-processing decode and condition-check helpers.
package arm_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXECR  = 4'd6,
      S_EXECI  = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9
   } state_e;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_MOV  = 3'b010;
   localparam logic [2:0] ALU_CMP  = 3'b011;
   localparam logic [2:0] ALU_SUBS = 3'b101;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam logic [3:0] FN_ADD = 4'b0100;
   localparam logic [3:0] FN_SUB = 4'b0010;
   localparam logic [3:0] FN_MOV = 4'b1101;
   localparam logic [3:0] FN_CMP = 4'b1010;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;

   typedef struct packed {
      logic       legal;
      logic [2:0] alu_ctrl;
      logic       flag_w;
      logic       no_write;
   } dp_dec_t;

   // S on ADD/MOV is dropped: bit2 of the ALU word would turn them into subtracts.
   function automatic dp_dec_t dp_decode(input logic [3:0] funct, input logic s);
      dp_dec_t d;
      d.legal    = 1'b1;
      d.alu_ctrl = ALU_ADD;
      d.flag_w   = 1'b0;
      d.no_write = 1'b0;
      case (funct)
         FN_ADD: d.alu_ctrl = ALU_ADD;
         FN_SUB: begin
            d.alu_ctrl = s ? ALU_SUBS : ALU_SUB;
            d.flag_w   = s;
         end
         FN_MOV: d.alu_ctrl = ALU_MOV;
         FN_CMP: begin
            d.alu_ctrl = ALU_CMP;
            d.flag_w   = 1'b1;
            d.no_write = 1'b1;
            d.legal    = s;
         end
         default: d.legal = 1'b0;
      endcase
      return d;
   endfunction

   function automatic logic cond_check(input logic [3:0] cond, input logic z);
      logic ok;
      case (cond)
         COND_AL: ok = 1'b1;
         COND_EQ: ok = z;
         COND_NE: ok = ~z;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/arm_cond_unit.sv
// Architectural Z flag, condition evaluation and gating of the write enables.
module arm_cond_unit
   import arm_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] cond,
   input  logic       flag_we,
   input  logic       alu_flag,
   input  logic       reg_write_req,
   input  logic       mem_write_req,
   input  logic       pc_write_req,
   output logic       zflag,
   output logic       cond_ex,
   output logic       reg_write,
   output logic       mem_write,
   output logic       pc_write
);

   logic zflag_r;

   // Z flag register, written only by a flag-setting instruction that executes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         zflag_r <= 1'b0;
      end else if (flag_we && cond_ex) begin
         zflag_r <= alu_flag;
      end else begin
         zflag_r <= zflag_r;
      end
   end

   assign zflag     = zflag_r;
   assign cond_ex   = cond_check(cond, zflag_r);
   assign reg_write = reg_write_req & cond_ex;
   assign mem_write = mem_write_req & cond_ex;
   assign pc_write  = pc_write_req & cond_ex;

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle control FSM for the ARM-subset datapath: decode, sequencing and
// combinational control outputs derived from state plus the captured decode.
module arm_mc_controller
   import arm_ctrl_pkg::*;
#(
   parameter logic [3:0] RESET_STATE = 4'd0
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] Instr,
   input  logic        ALUFlags,
   output logic [2:0]  ALUControl,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic [1:0]  ResultSrc,
   output logic        AdrSrc,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        ZFlag,
   output logic        Illegal
);

   state_e     state_r;
   dp_dec_t    dec_s;
   dp_dec_t    dec_r;
   logic [3:0] cond_r;
   logic       load_r;
   logic       illegal_s;
   logic       cond_ex_s;
   logic       flag_we_s;
   logic       reg_write_req_s;
   logic       mem_write_req_s;
   logic       pc_write_req_s;
   logic       reg_write_s;
   logic       mem_write_s;
   logic       pc_write_s;
   logic       unused_s;

   assign dec_s    = dp_decode(Instr[24:21], Instr[20]);
   assign unused_s = ^{Instr[19:0], cond_ex_s};

   // Live decode legality, only meaningful while in DECODE.
   always_comb begin
      illegal_s = 1'b0;
      if (Instr[27:26] == 2'b11) begin
         illegal_s = 1'b1;
      end else if (Instr[27:26] == OP_DP) begin
         illegal_s = ~dec_s.legal;
      end else begin
         illegal_s = 1'b0;
      end
   end

   // Sequencer; the decode is latched on leaving DECODE so later Instr changes are ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= state_e'(RESET_STATE);
         dec_r   <= '0;
         cond_r  <= 4'd0;
         load_r  <= 1'b0;
      end else begin
         case (state_r)
            S_FETCH:  state_r <= S_DECODE;
            S_DECODE: begin
               dec_r  <= dec_s;
               cond_r <= Instr[31:28];
               load_r <= Instr[20];
               if (illegal_s) begin
                  state_r <= S_FETCH;
               end else begin
                  case (Instr[27:26])
                     OP_MEM:  state_r <= S_MEMADR;
                     OP_BR:   state_r <= S_BRANCH;
                     default: state_r <= Instr[25] ? S_EXECI : S_EXECR;
                  endcase
               end
            end
            S_MEMADR: state_r <= load_r ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_r <= S_MEMWB;
            S_EXECR:  state_r <= S_ALUWB;
            S_EXECI:  state_r <= S_ALUWB;
            S_MEMWB:  state_r <= S_FETCH;
            S_MEMWR:  state_r <= S_FETCH;
            S_ALUWB:  state_r <= S_FETCH;
            S_BRANCH: state_r <= S_FETCH;
            default:  state_r <= S_FETCH;
         endcase
      end
   end

   assign flag_we_s       = ((state_r == S_EXECR) || (state_r == S_EXECI)) && dec_r.flag_w;
   assign reg_write_req_s = ((state_r == S_ALUWB) && !dec_r.no_write) || (state_r == S_MEMWB);
   assign mem_write_req_s = (state_r == S_MEMWR);
   assign pc_write_req_s  = (state_r == S_BRANCH);

   arm_cond_unit u_cond (
      .clk           (clk),
      .reset_n       (reset_n),
      .cond          (cond_r),
      .flag_we       (flag_we_s),
      .alu_flag      (ALUFlags),
      .reg_write_req (reg_write_req_s),
      .mem_write_req (mem_write_req_s),
      .pc_write_req  (pc_write_req_s),
      .zflag         (ZFlag),
      .cond_ex       (cond_ex_s),
      .reg_write     (reg_write_s),
      .mem_write     (mem_write_s),
      .pc_write      (pc_write_s)
   );

   // Control word per state; everything is forced quiet while reset is held.
   always_comb begin
      ALUControl = ALU_ADD;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ImmSrc     = 2'b00;
      RegSrc     = 2'b00;
      ResultSrc  = 2'b00;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      MemWrite   = 1'b0;
      Illegal    = 1'b0;
      if (reset_n) begin
         RegWrite = reg_write_s;
         MemWrite = mem_write_s;
         PCWrite  = pc_write_s;
         case (state_r)
            S_FETCH: begin
               ALUSrcA   = 1'b1;
               ALUSrcB   = 2'b10;
               ResultSrc = 2'b10;
               IRWrite   = 1'b1;
               PCWrite   = 1'b1;
            end
            S_DECODE: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               Illegal = illegal_s;
            end
            S_EXECR:  ALUControl = dec_r.alu_ctrl;
            S_EXECI: begin
               ALUControl = dec_r.alu_ctrl;
               ALUSrcB    = 2'b01;
            end
            S_MEMADR: begin
               ALUSrcB = 2'b01;
               ImmSrc  = 2'b01;
               RegSrc  = {~load_r, 1'b0};
            end
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWB:  ResultSrc = 2'b01;
            S_MEMWR:  AdrSrc = 1'b1;
            S_BRANCH: begin
               RegSrc    = 2'b01;
               ALUSrcB   = 2'b01;
               ImmSrc    = 2'b10;
               ResultSrc = 2'b10;
            end
            default:  ALUControl = ALU_ADD;
         endcase
      end else begin
         ALUControl = ALU_ADD;
      end
   end

endmodule

// File: tb/tb_arm_mc_controller.sv
// Randomized bench for arm_mc_controller against an instruction-level reference model.
module tb_arm_mc_controller;

   typedef struct packed {
      logic [2:0] alu;
      logic       srca;
      logic [1:0] srcb;
      logic [1:0] imm;
      logic [1:0] regsrc;
      logic [1:0] res;
      logic       adr;
      logic       irw;
      logic       pcw;
      logic       rw;
      logic       mw;
      logic       z;
      logic       ill;
   } ovec_t;

   localparam int K_ILL = 0;
   localparam int K_DP  = 1;
   localparam int K_MEM = 2;
   localparam int K_BR  = 3;

   logic        clk;
   logic        reset_n;
   logic [31:0] Instr;
   logic        ALUFlags;
   logic [2:0]  ALUControl;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ImmSrc;
   logic [1:0]  RegSrc;
   logic [1:0]  ResultSrc;
   logic        AdrSrc;
   logic        IRWrite;
   logic        PCWrite;
   logic        RegWrite;
   logic        MemWrite;
   logic        ZFlag;
   logic        Illegal;

   int   n_checks;
   int   n_pass;
   int   n_instr;
   logic model_z;

   arm_mc_controller dut (
      .clk(clk), .reset_n(reset_n), .Instr(Instr), .ALUFlags(ALUFlags),
      .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .RegSrc(RegSrc), .ResultSrc(ResultSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .ZFlag(ZFlag),
      .Illegal(Illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic int kind_of(input logic [31:0] ins);
      logic [3:0] f;
      f = ins[24:21];
      case (ins[27:26])
         2'b01:   return K_MEM;
         2'b10:   return K_BR;
         2'b00:   return (f == 4'h4 || f == 4'h2 || f == 4'hD || (f == 4'hA && ins[20])) ? K_DP : K_ILL;
         default: return K_ILL;
      endcase
   endfunction

   function automatic int instr_len(input logic [31:0] ins);
      case (kind_of(ins))
         K_DP:    return 4;
         K_MEM:   return ins[20] ? 5 : 4;
         K_BR:    return 3;
         default: return 2;
      endcase
   endfunction

   function automatic logic executes(input logic [31:0] ins, input logic z);
      case (ins[31:28])
         4'hE:    return 1'b1;
         4'h0:    return z;
         4'h1:    return !z;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] alu_word(input logic [31:0] ins);
      case (ins[24:21])
         4'h4:    return 3'd0;
         4'h2:    return ins[20] ? 3'd5 : 3'd1;
         4'hD:    return 3'd2;
         4'hA:    return 3'd3;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic sets_z(input logic [31:0] ins);
      return (ins[24:21] == 4'hA) || (ins[24:21] == 4'h2 && ins[20]);
   endfunction

   // Expected control word for cycle k of an instruction, given the current Z.
   function automatic ovec_t expect_vec(input logic [31:0] ins, input int k, input logic z);
      ovec_t e;
      logic  c;
      e   = '0;
      e.z = z;
      c   = executes(ins, z);
      if (k == 0) begin
         e.srca = 1'b1; e.srcb = 2'd2; e.res = 2'd2; e.irw = 1'b1; e.pcw = 1'b1;
      end else if (k == 1) begin
         e.srca = 1'b1; e.srcb = 2'd2; e.ill = (kind_of(ins) == K_ILL);
      end else begin
         case (kind_of(ins))
            K_DP: begin
               if (k == 2) begin
                  e.srcb = ins[25] ? 2'd1 : 2'd0;
                  e.alu  = alu_word(ins);
               end else begin
                  e.rw = c && (ins[24:21] != 4'hA);
               end
            end
            K_MEM: begin
               if (k == 2) begin
                  e.srcb = 2'd1; e.imm = 2'd1; e.regsrc = ins[20] ? 2'd0 : 2'd2;
               end else if (ins[20] && k == 3) begin
                  e.adr = 1'b1;
               end else if (ins[20]) begin
                  e.res = 2'd1; e.rw = c;
               end else begin
                  e.adr = 1'b1; e.mw = c;
               end
            end
            K_BR: begin
               e.regsrc = 2'd1; e.srcb = 2'd1; e.imm = 2'd2; e.res = 2'd2; e.pcw = c;
            end
            default: e = '0;
         endcase
      end
      return e;
   endfunction

   // Runs one instruction from its FETCH cycle; optionally pulls reset at step abort_step.
   task automatic run_instr(input logic [31:0] ins, input int abort_step, input int flag);
      ovec_t got;
      ovec_t exp;
      n_instr++;
      for (int k = 0; k < instr_len(ins); k++) begin
         Instr    = (k < 2) ? ins : $urandom;
         ALUFlags = (flag < 0) ? 1'($urandom) : 1'(flag);
         if (k == abort_step) begin
            reset_n = 1'b0;
            #1;
            chk($sformatf("i%0d.rst", n_instr),
                {23'd0, IRWrite, PCWrite, RegWrite, MemWrite, Illegal, ZFlag, ALUControl}, 32'd0);
            model_z = 1'b0;
            @(posedge clk);
            #1;
            reset_n = 1'b1;
            return;
         end
         @(negedge clk);
         got = {ALUControl, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ResultSrc, AdrSrc,
                IRWrite, PCWrite, RegWrite, MemWrite, ZFlag, Illegal};
         exp = expect_vec(ins, k, model_z);
         chk($sformatf("i%0d.%08h.s%0d", n_instr, ins, k), 32'(got), 32'(exp));
         if (k == 2 && kind_of(ins) == K_DP && sets_z(ins) && executes(ins, model_z)) begin
            model_z = ALUFlags;
         end
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [3:0]  conds [4];
      logic [3:0]  fns [4];
      conds = '{4'h0, 4'h1, 4'hE, 4'hE};
      fns   = '{4'h4, 4'h2, 4'hD, 4'hA};
      r = $urandom;
      case ($urandom_range(0, 9))
         0:       r[27:26] = 2'b11;
         1, 2:    r[27:26] = 2'b01;
         3, 4:    r[27:26] = 2'b10;
         default: begin
            r[27:26] = 2'b00;
            if ($urandom_range(0, 5) != 0) r[24:21] = fns[$urandom_range(0, 3)];
         end
      endcase
      if ($urandom_range(0, 4) != 0) r[31:28] = conds[$urandom_range(0, 3)];
      return r;
   endfunction

   initial begin
      n_checks = 0;
      n_pass   = 0;
      n_instr  = 0;
      model_z  = 1'b0;
      reset_n  = 1'b0;
      Instr    = 32'd0;
      ALUFlags = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset", {23'd0, IRWrite, PCWrite, RegWrite, MemWrite, Illegal, ZFlag, ALUControl}, 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      run_instr(32'hE0812002, -1, -1);   // ADD AL
      run_instr(32'hE1510002, -1, 1);    // CMP, Z<=1
      run_instr(32'h0A000001, -1, -1);   // BEQ taken
      run_instr(32'hE5912000, 3, -1);    // LDR, reset in MEMRD
      run_instr(32'h0A000001, -1, -1);   // BEQ untaken after reset
      run_instr(32'hE1510002, -1, 1);
      run_instr(32'hE1510002, -1, 0);    // CMP, Z<=0
      run_instr(32'h0A000001, -1, -1);
      run_instr(32'hE0512003, -1, 1);    // SUBS, Z<=1
      run_instr(32'hE0412003, -1, 0);    // SUB, Z held
      run_instr(32'h15812000, -1, -1);   // STRNE, Z=1
      run_instr(32'hE1510002, -1, 0);
      run_instr(32'h15812000, -1, -1);   // STRNE, Z=0
      run_instr(32'hE5912000, -1, -1);   // LDR full
      run_instr(32'hEC000000, -1, -1);   // illegal op
      run_instr(32'hE0012002, -1, -1);   // illegal funct
      run_instr(32'hE1410002, -1, -1);   // CMP without S
      run_instr(32'hE0812002, -1, -1);

      for (int i = 0; i < 300; i++) begin
         run_instr(rand_instr(), ($urandom_range(0, 39) == 0) ? 2 : -1, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/arm_mc_controller.md
Name: arm_mc_controller

Overview:
- Multicycle control unit for the ARM-subset datapath. Drives the 3-bit ALU control word and consumes the single ALU flag (Z); it is the producer/consumer at the other end of the ALU control/flag interface.
- Holds the architectural Z flag, evaluates condition codes, and sequences fetch/decode/execute/memory/writeback for ADD, SUB, MOV, CMP, LDR, STR and B.

Parameters:
- RESET_STATE, 4'd0 (FETCH), state entered on reset.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset
- Instr  input  32  instruction register contents, stable from DECODE onward
- ALUFlags  input  1  ALU zero result, valid in the same cycle as ALUControl
- ALUControl  output  3  ALU op: 000 add, 001 sub, 010 pass SrcB, 011 cmp; bit2 forces sub plus flag
- ALUSrcA  output  1  0=register A, 1=PC
- ALUSrcB  output  2  00=register B, 01=ExtImm, 10=constant 4
- ImmSrc  output  2  00=imm8, 01=imm12, 10=imm24 branch
- RegSrc  output  2  [0]=PC as Rn (B), [1]=Rd as 2nd read (STR)
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- AdrSrc  output  1  0=PC, 1=ALUOut
- IRWrite, PCWrite, RegWrite, MemWrite  output  1 each  enables
- ZFlag  output  1  architectural Z
- Illegal  output  1  pulse: unsupported encoding decoded

Interface note: one clock; reset is asynchronous and active-low (clk, reset_n).

Behaviour:
- Reset (reset_n low, any time, async): state=FETCH, ZFlag=0, all enables 0, ALUControl=000, Illegal=0. On reset_n rising, the FSM runs from FETCH on the next clk edge.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=000, ResultSrc=10, PCWrite=1. Next state is DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=000 (PC+8 read). Next state by Instr[27:26]:
  - 01 goes to MEMADR.
  - 10 goes to BRANCH.
  - 00 goes to EXECI if Instr[25]=1, else EXECR.
  - 11 pulses Illegal and goes to FETCH.
- Data-processing decode, funct=Instr[24:21], S=Instr[20]:
  - 0100 ADD gives 000.
  - 0010 SUB gives 001, or 101 if S=1.
  - 1101 MOV gives 010.
  - 1010 CMP gives 011 and requires S=1.
  - Any other funct, or CMP with S=0, pulses Illegal in DECODE and goes to FETCH.
  - S on ADD/MOV is ignored; flags are unchanged, because bit2 would force subtraction.
- FlagW = CMP or SUBS. NoWrite = CMP.
- Condition check: Cond=Instr[31:28]; CondEx = (Cond==1110) or (Cond==0000 and ZFlag) or (Cond==0001 and !ZFlag). Any other Cond is never executed and does not raise Illegal.
- EXECR/EXECI: ALUSrcA=0, ALUSrcB=00 or 01, ImmSrc=00, ALUControl per decode.
  - If FlagW and CondEx, ZFlag<=ALUFlags at the end of this cycle.
  - Next state is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=CondEx & !NoWrite. Next state is FETCH.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ImmSrc=01, ALUControl=000.
  - Instr[20]=1 goes to MEMRD; otherwise RegSrc[1]=1 and the next state is MEMWR.
- MEMRD: AdrSrc=1. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx. Next state is FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondEx. Next state is FETCH.
- BRANCH: RegSrc[0]=1, ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ALUControl=000, ResultSrc=10, PCWrite=CondEx. Next state is FETCH.
- Latencies (cycles per instruction): B=3, STR=4, DP=4, LDR=5, Illegal=2.
- Gating: the condition never changes the sequence, only the enables. An untaken instruction still spends its full cycle count.
- Outputs are combinational from state plus the registered decode. Decode is captured in DECODE and held until the next FETCH, so Instr changes after DECODE are ignored.
- ZFlag is written only on the EXEC→ALUWB edge. A CMP followed by BEQ observes the new Z.

Decomposition:
- Package arm_ctrl_pkg:
  - state enum (4-bit)
  - ALUControl codes: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_MOV=3'b010, ALU_CMP=3'b011, ALU_SUBS=3'b101
  - cond codes: EQ, NE, AL
  - funct codes
- Sub-module arm_cond_unit: holds ZFlag, computes CondEx, gates RegWrite/MemWrite/PCWrite.
- FSM and decode stay in the top module.

Test Plan:
- Reset mid-LDR (assert reset_n=0 in MEMRD): state=FETCH, ZFlag=0, all enables 0 immediately. On release, FETCH asserts IRWrite=1, PCWrite=1.
- ADD AL (0xE0812002): 4 cycles. EXECR ALUControl=000, ALUWB RegWrite=1, ZFlag unchanged.
- CMP then BEQ: CMP (0xE1510002) with ALUFlags=1 in EXECR gives ZFlag=1. Next BEQ (0x0A000001) gives BRANCH PCWrite=1. Repeat with ALUFlags=0: PCWrite=0, still 3 cycles.
- SUBS (0xE0512003): ALUControl=101, ZFlag<=ALUFlags. SUB without S (0xE0412003): ALUControl=001, ZFlag held.
- STRNE with ZFlag=1 (0x15812000): MEMADR→MEMWR, RegSrc[1]=1, MemWrite=0. With ZFlag=0: MemWrite=1.
- Illegal: op=11 (0xEC000000) or funct=0000 (0xE0012002) gives an Illegal pulse in DECODE, then FETCH, with no RegWrite, MemWrite or PCWrite after FETCH.
